// File: rtl/spi_flash_rescue_seq.sv
// Brings an N25Q128 to a known state: power-loss rescue bursts on S#/DQ0, then FSR (0x70) polling until ready.
// Define FLASH_SWRST_EN to insert 0x66 / 0x99 software-reset frames between the rescue bursts and polling.
module spi_flash_rescue_seq #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int POLL_MAX   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [7:0] fsr_o,
    output logic [4:0] poll_cnt_o,
    output logic       sck_o,
    output logic       cs_no,
    output logic       dq0_o,
    input  logic       dq1_i
);
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, RESC, GAP,
`ifdef FLASH_SWRST_EN
        SWRST,
`endif
        CMD, RD, CHK, DONE
    } state_t;

    // Position inside one S# frame: lead-in, SCK low/high halves, tail before S# rises.
    typedef enum logic [1:0] {SUB_LEAD, SUB_LOW, SUB_HIGH, SUB_TRAIL} sub_t;

    state_t          state_q, state_d, gap_nxt_q, gap_nxt_d;
    sub_t            sub_q, sub_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [4:0]      bcnt_q, bcnt_d, last_idx;
    logic [1:0]      burst_q, burst_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      rx_q, rx_d, fsr_q, fsr_d, tx_byte;
    logic [4:0]      poll_q, poll_d, poll_inc;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            sck_q, sck_d, cs_n_q, cs_n_d, dq0_q, dq0_d;
    logic [2:0]      nxt_pos;
`ifdef FLASH_SWRST_EN
    logic            sw_q, sw_d;
`endif

    always_comb begin
        tx_byte = 8'hFF;
        if (state_q == CMD) tx_byte = 8'h70;
`ifdef FLASH_SWRST_EN
        else if (state_q == SWRST) tx_byte = sw_q ? 8'h99 : 8'h66;
`endif
    end

    always_comb begin
        last_idx = 5'd7;
        if (state_q == RESC) begin
            case (burst_q)
                2'd0:    last_idx = 5'd6;
                2'd1:    last_idx = 5'd12;
                2'd2:    last_idx = 5'd24;
                default: last_idx = 5'd7;
            endcase
        end
    end

    assign nxt_pos  = 3'd6 - bcnt_q[2:0];
    assign poll_inc = (poll_q == 5'd31) ? poll_q : poll_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        gap_nxt_d = gap_nxt_q;
        ph_d      = ph_q;
        bcnt_d    = bcnt_q;
        burst_d   = burst_q;
        gap_d     = gap_q;
        rx_d      = rx_q;
        fsr_d     = fsr_q;
        poll_d    = poll_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        dq0_d     = dq0_q;
`ifdef FLASH_SWRST_EN
        sw_d      = sw_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RESC;
                    sub_d   = SUB_LEAD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    fsr_d   = 8'h00;
                    poll_d  = 5'd0;
                    burst_d = 2'd0;
`ifdef FLASH_SWRST_EN
                    sw_d    = 1'b0;
`endif
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES)) begin
                    state_d = gap_nxt_q;
                    sub_d   = SUB_LEAD;
                    cs_n_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            CHK: begin
                fsr_d  = rx_q;
                poll_d = poll_inc;
                if (rx_q[7] || int'(poll_inc) >= POLL_MAX) begin
                    err_d   = ~rx_q[7];
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = GAP;
                    gap_d     = GW'(1);
                    gap_nxt_d = CMD;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                case (sub_q)
                    SUB_LEAD: begin
                        sub_d  = SUB_LOW;
                        ph_d   = '0;
                        bcnt_d = 5'd0;
                        dq0_d  = tx_byte[7];
                    end
                    SUB_LOW: begin
                        if (ph_q == PW'(CLK_DIV - 1)) begin
                            sub_d = SUB_HIGH;
                            ph_d  = '0;
                            sck_d = 1'b1;
                        end else begin
                            ph_d = ph_q + 1'b1;
                        end
                    end
                    SUB_HIGH: begin
                        if (ph_q == '0 && state_q == RD) rx_d = {rx_q[6:0], dq1_i};
                        if (ph_q == PW'(CLK_DIV - 1)) begin
                            sck_d = 1'b0;
                            ph_d  = '0;
                            if (bcnt_q != last_idx) begin
                                bcnt_d = bcnt_q + 5'd1;
                                sub_d  = SUB_LOW;
                                dq0_d  = tx_byte[nxt_pos];
                            end else if (state_q == CMD) begin
                                // Read phase follows the command inside the same S# frame.
                                state_d = RD;
                                sub_d   = SUB_LOW;
                                bcnt_d  = 5'd0;
                                dq0_d   = 1'b1;
                            end else begin
                                sub_d = SUB_TRAIL;
                            end
                        end else begin
                            ph_d = ph_q + 1'b1;
                        end
                    end
                    default: begin
                        cs_n_d  = 1'b1;
                        dq0_d   = 1'b1;
                        gap_d   = GW'(1);
                        state_d = GAP;
                        if (state_q == RD) begin
                            state_d = CHK;
                        end else if (state_q == RESC) begin
                            if (burst_q == 2'd3) begin
`ifdef FLASH_SWRST_EN
                                gap_nxt_d = SWRST;
`else
                                gap_nxt_d = CMD;
`endif
                            end else begin
                                burst_d   = burst_q + 2'd1;
                                gap_nxt_d = RESC;
                            end
                        end
`ifdef FLASH_SWRST_EN
                        else if (state_q == SWRST) begin
                            gap_nxt_d = sw_q ? CMD : SWRST;
                            sw_d      = 1'b1;
                        end
`endif
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sub_q     <= SUB_LEAD;
            gap_nxt_q <= IDLE;
            ph_q      <= '0;
            bcnt_q    <= 5'd0;
            burst_q   <= 2'd0;
            gap_q     <= '0;
            rx_q      <= 8'h00;
            fsr_q     <= 8'h00;
            poll_q    <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            dq0_q     <= 1'b1;
`ifdef FLASH_SWRST_EN
            sw_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            gap_nxt_q <= gap_nxt_d;
            ph_q      <= ph_d;
            bcnt_q    <= bcnt_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
            rx_q      <= rx_d;
            fsr_q     <= fsr_d;
            poll_q    <= poll_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            dq0_q     <= dq0_d;
`ifdef FLASH_SWRST_EN
            sw_q      <= sw_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = err_q;
    assign fsr_o      = fsr_q;
    assign poll_cnt_o = poll_q;
    assign sck_o      = sck_q;
    assign cs_no      = cs_n_q;
    assign dq0_o      = dq0_q;
endmodule
